// File: rtl/dz_pkg.sv
// Shared types and shape constants for the dot-matrix egg sequencer and display driver.
package dz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } dz_seq_state_t;

    localparam logic [2:0] DZ_NUM_BLANK = 3'd0;
    localparam logic [2:0] DZ_NUM_FIRST = 3'd1;
    localparam logic [2:0] DZ_NUM_LAST  = 3'd4;

endpackage

// File: rtl/dz_edge_det.sv
// 1-bit rising-edge detector; history resets high so a level held through reset never fires.
module dz_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= d_i;
        end
    end

    assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/dz_egg_seq.sv
// Egg-shape sequencer: steps num 1..4 then blank every STEP_MS clocks, with start/pause buttons.
// Optional build macro DZ_EGG_SEQ_DONE_BLINK_EN blinks num 4/0 in DONE every BLINK_MS clocks.
module dz_egg_seq
    import dz_pkg::*;
#(
    parameter int STEP_MS  = 500,
    parameter int BLINK_MS = 250,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    output logic [2:0]    num,
    output logic          running,
    output logic          done,
    output dz_seq_state_t dbg_state_o
);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_MS - 1);

    if (STEP_MS < 2 || BLINK_MS < 1 || CNT_W < 2) begin : g_bad_param
        $error("dz_egg_seq: illegal STEP_MS/BLINK_MS/CNT_W");
    end

    dz_seq_state_t    state_q;
    logic [2:0]       num_q;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic             done_q;

    logic start_rise;
    logic pause_rise;
    logic step_end;
    logic seq_end;

    dz_edge_det u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (start),
        .rise_o (start_rise)
    );

    dz_edge_det u_pause_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pause),
        .rise_o (pause_rise)
    );

    assign step_end = (cnt_q == STEP_LAST);
    // The final stage ending goes straight to DONE; a coincident pause is dropped there.
    assign seq_end  = step_end && (num_q == DZ_NUM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= DZ_NUM_BLANK;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (start_rise) begin
            state_q   <= RUN;
            num_q     <= DZ_NUM_FIRST;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (step_end) begin
                        cnt_q <= '0;
                        if (seq_end) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
`ifdef DZ_EGG_SEQ_DONE_BLINK_EN
                            num_q     <= DZ_NUM_LAST;
`else
                            num_q     <= DZ_NUM_BLANK;
`endif
                        end else begin
                            num_q <= num_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (pause_rise && !seq_end) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pause_rise) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
`ifdef DZ_EGG_SEQ_DONE_BLINK_EN
                    if (cnt_q == CNT_W'(BLINK_MS - 1)) begin
                        cnt_q <= '0;
                        num_q <= (num_q == DZ_NUM_LAST) ? DZ_NUM_BLANK : DZ_NUM_LAST;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                IDLE: begin
                end
                default: begin
                    state_q   <= IDLE;
                    num_q     <= DZ_NUM_BLANK;
                    cnt_q     <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign num         = num_q;
    assign running     = running_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
